dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port burst arbiter that shares the single-port data memory (word-addressed, combinational read, synchronous write) between two requesters, e.g. the core's load/store unit (port 0) and a DMA/debug engine (port 1). It latches one request at a time, issues 1–4 consecutive word beats to the memory, and returns registered read data. Round-robin priority keeps both ports from starving. It sits between the requesters and the memory's MemWrite/Addr/WriteData/ReadData pins.

## Interface

Parameters
- none; widths fixed (16-bit byte address, 32-bit data, 2-bit burst length).

Ports (N = 0, 1; each port has an identical set)
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- pN_req  input  1  request pending; sampled only in IDLE.
- pN_we  input  1  1 = write burst, 0 = read burst; latched at grant.
- pN_addr  input  16  byte base address; latched at grant; bits [1:0] ignored.
- pN_len  input  2  beats minus one (0 → 1 beat, 3 → 4 beats); latched at grant.
- pN_wdata  input  32  write data for the current beat; sampled combinationally during each write beat.
- pN_gnt  output  1  high for every cycle port N owns the memory (BURST state).
- pN_beat  output  1  high in a cycle where a beat of port N is performed on the memory.
- pN_rvalid  output  1  registered; high the cycle after a read beat of port N.
- pN_rdata  output  32  registered read data; valid when pN_rvalid.
- pN_done  output  1  registered one-cycle pulse, the cycle after the last beat of port N's burst.
- MemWrite  output  1  memory write enable.
- Addr  output  16  memory byte address, bits [1:0] always 00.
- WriteData  output  32  memory write data.
- ReadData  input  32  memory combinational read data.

## Operation

- States: IDLE, BURST. Registers: owner (1 bit), we_l, base_l[15:0], len_l[1:0], cnt[1:0], prio (1 bit, port preferred on tie).
- IDLE: if exactly one pN_req is high, grant N; if both are high, grant prio. On grant, latch we/addr/len of N, set cnt = 0, go to BURST. If no request, stay in IDLE.
- BURST: every cycle is one beat for owner.
  - Addr = {base_l[15:2] + cnt, 2'b00}; the 14-bit word index wraps modulo 2^14 (0xFFFC + 1 beat → 0x0000).
  - MemWrite = we_l; WriteData = owner's pN_wdata; pN_beat = 1.
  - On a read beat, ReadData is captured into pN_rdata at the clock edge and pN_rvalid goes high the next cycle.
  - If cnt == len_l: pulse pN_done next cycle, set prio = ~owner, return to IDLE. Otherwise cnt++.
- Once granted, a burst always runs to completion; pN_req deasserting mid-burst has no effect. Requests from the non-owner are held off; the arbiter looks at them in the next IDLE cycle.
- Non-owner port: gnt/beat/rvalid/done stay 0, and its rdata holds its last value.
- In IDLE: MemWrite = 0, Addr = 0, WriteData = 0.

## Timing

- Reset values: state IDLE, prio = 0 (port 0 preferred), all gnt/beat/rvalid/done = 0, rdata = 0, MemWrite = 0, Addr = 0, WriteData = 0, cnt = 0.
- Grant latency: req seen in IDLE at edge k → BURST from cycle k+1; first beat in cycle k+1.
- An L-beat burst occupies L cycles in BURST followed by 1 mandatory IDLE cycle. Minimum request-to-request period is L+1 cycles.
- Read latency: beat in cycle c → pN_rvalid/pN_rdata in cycle c+1. done is coincident with the last rvalid.
- A write beat commits at the end of its beat cycle. A read beat in the following burst sees that data.
- Reset mid-burst: at the reset edge the burst is aborted, and no further beats or done pulse occur. MemWrite is 0 from the cycle after that edge. Writes from beats before the reset edge remain committed.
- Simultaneous requests with equal priority history: resolved by prio only; no other tie-break.

## Test plan

- Reset, then p0 write, addr 0x0010, len 3, wdata 0xA0..0xA3 per beat → MemWrite high 4 cycles, Addr 0x10, 0x14, 0x18, 0x1C; p0_done pulses in cycle 5; a following read of the same range returns 0xA0..0xA3 with rvalid in 4 consecutive cycles.
- Both req high from reset, len 0 each → p0 granted first, p1 next IDLE cycle; then sustained both-high alternates p0, p1, p0… (no starvation).
- p1 read burst len 2 while p0 requests at the 2nd beat → p0 not granted until the IDLE cycle after p1 done; p0_gnt never overlaps p1_gnt.
- Wrap: p1 write addr 0xFFFC, len 1, data 0x11, 0x22 → Addr 0xFFFC then 0x0000; readback 0x11 at 0xFFFC and 0x22 at 0x0000.
- Addr low bits: p0 read addr 0x0013 → Addr 0x0010 on the memory.
- Reset asserted during 2nd beat of a len-3 write → only beats 1–2 committed, no done, all outputs at reset values; next request is granted normally with p0 preferred.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Requester-side signal bundle for one dm_arbiter port.
// The master modport is the requester; the slave modport is the arbiter.
interface dm_arbiter_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [1:0]  len;
  logic [31:0] wdata;
  logic        gnt;
  logic        beat;
  logic        rvalid;
  logic [31:0] rdata;
  logic        done;

  modport master (
    output req, we, addr, len, wdata,
    input  gnt, beat, rvalid, rdata, done
  );

  modport slave (
    input  req, we, addr, len, wdata,
    output gnt, beat, rvalid, rdata, done
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin burst arbiter in front of a single-port data memory.
// state | meaning
// IDLE  | no owner; sample requests, grant one, latch its burst parameters
// BURST | owner performs one memory beat per cycle until cnt reaches len
module dm_arbiter (
  input  logic          clk,
  input  logic          reset,
  dm_arbiter_if.slave   p0,
  dm_arbiter_if.slave   p1,
  output logic          MemWrite,
  output logic [15:0]   Addr,
  output logic [31:0]   WriteData,
  input  logic [31:0]   ReadData
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        owner_q;
  logic        we_l;
  logic [15:2] base_l;
  logic [1:0]  len_l;
  logic [1:0]  cnt_q;
  logic        prio_q;
  logic [1:0]  rvalid_q;
  logic [1:0]  done_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        grant;
  logic        gnt_port;
  logic        last_beat;
  logic        in_burst;
  logic [13:0] word_idx;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{p0.addr[1:0], p1.addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    gnt_port  = prio_q;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0.req || p1.req) begin
          grant    = 1'b1;
          gnt_port = (p0.req && p1.req) ? prio_q : p1.req;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (cnt_q == len_l) begin
          last_beat = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= 1'b0;
      we_l     <= 1'b0;
      base_l   <= '0;
      len_l    <= '0;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
      rvalid_q <= '0;
      done_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= '0;
      done_q   <= '0;
      if (grant) begin
        owner_q <= gnt_port;
        we_l    <= gnt_port ? p1.we : p0.we;
        base_l  <= gnt_port ? p1.addr[15:2] : p0.addr[15:2];
        len_l   <= gnt_port ? p1.len : p0.len;
        cnt_q   <= '0;
      end
      if (in_burst) begin
        if (!we_l) begin
          if (owner_q) rdata1_q <= ReadData;
          else         rdata0_q <= ReadData;
          rvalid_q[owner_q] <= 1'b1;
        end
        // The finishing port loses the next tie so neither side can starve.
        if (last_beat) begin
          done_q[owner_q] <= 1'b1;
          prio_q          <= ~owner_q;
        end else begin
          cnt_q <= cnt_q + 2'd1;
        end
      end
    end
  end

  assign in_burst  = (state_q == BURST);
  assign word_idx  = base_l + {12'd0, cnt_q};
  assign MemWrite  = in_burst && we_l;
  assign Addr      = in_burst ? {word_idx, 2'b00} : 16'h0000;
  assign WriteData = in_burst ? (owner_q ? p1.wdata : p0.wdata) : 32'h0;

  assign p0.gnt    = in_burst && !owner_q;
  assign p0.beat   = in_burst && !owner_q;
  assign p0.rvalid = rvalid_q[0];
  assign p0.rdata  = rdata0_q;
  assign p0.done   = done_q[0];

  assign p1.gnt    = in_burst && owner_q;
  assign p1.beat   = in_burst && owner_q;
  assign p1.rvalid = rvalid_q[1];
  assign p1.rdata  = rdata1_q;
  assign p1.done   = done_q[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Cycle-vector bench for dm_arbiter with a behavioural word memory attached.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [15:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] mem [0:16383];

  int n_vec = 0;
  int n_err = 0;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  always #5 clk = ~clk;

  dm_arbiter_if p0_if ();
  dm_arbiter_if p1_if ();

  dm_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p0        (p0_if),
    .p1        (p1_if),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData)
  );

  assign ReadData = mem[Addr[15:2]];
  always @(posedge clk) if (MemWrite) mem[Addr[15:2]] <= WriteData;

  typedef struct {
    logic        rst;
    logic        r0, we0;
    logic [1:0]  l0;
    logic [15:0] a0;
    logic [31:0] wd0;
    logic        r1, we1;
    logic [1:0]  l1;
    logic [15:0] a1;
    logic [31:0] wd1;
    logic        mw;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [1:0]  gnt, beat, rv;
    logic [31:0] rd0, rd1;
    logic [1:0]  dn;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rst,
    input logic r0, input logic we0, input logic [1:0] l0, input logic [15:0] a0, input logic [31:0] wd0,
    input logic r1, input logic we1, input logic [1:0] l1, input logic [15:0] a1, input logic [31:0] wd1,
    input logic mw, input logic [15:0] addr, input logic [31:0] wd,
    input logic [1:0] gnt, input logic [1:0] beat, input logic [1:0] rv,
    input logic [31:0] rd0, input logic [31:0] rd1, input logic [1:0] dn);
    vec_t t;
    t.rst = rst;
    t.r0 = r0; t.we0 = we0; t.l0 = l0; t.a0 = a0; t.wd0 = wd0;
    t.r1 = r1; t.we1 = we1; t.l1 = l1; t.a1 = a1; t.wd1 = wd1;
    t.mw = mw; t.addr = addr; t.wd = wd;
    t.gnt = gnt; t.beat = beat; t.rv = rv;
    t.rd0 = rd0; t.rd1 = rd1; t.dn = dn;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    reset        = t.rst;
    p0_if.req    = t.r0;  p0_if.we = t.we0; p0_if.len = t.l0; p0_if.addr = t.a0; p0_if.wdata = t.wd0;
    p1_if.req    = t.r1;  p1_if.we = t.we1; p1_if.len = t.l1; p1_if.addr = t.a1; p1_if.wdata = t.wd1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [127:0] act_v, exp_v;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    drive(mk(Y, N,N,2'd0,16'h0,32'h0, N,N,2'd0,16'h0,32'h0, N,16'h0,32'h0, 2'b00,2'b00,2'b00, 32'h0,32'h0, 2'b00));

    // rst, p0{req,we,len,addr,wdata}, p1{...} | MemWrite, Addr, WriteData, gnt, beat, rvalid, rdata0, rdata1, done
    // reset, then p0 4-beat write and readback
    tv.push_back(mk(Y, N,N,2'd0,16'h0000,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, Y,Y,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,Y,2'd3,16'h0010,32'hA0, N,N,2'd0,16'h0000,32'h00, Y,16'h0010,32'hA0, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,Y,2'd3,16'h0010,32'hA1, N,N,2'd0,16'h0000,32'h00, Y,16'h0014,32'hA1, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,Y,2'd3,16'h0010,32'hA2, N,N,2'd0,16'h0000,32'h00, Y,16'h0018,32'hA2, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,Y,2'd3,16'h0010,32'hA3, N,N,2'd0,16'h0000,32'h00, Y,16'h001C,32'hA3, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, Y,N,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'h00,32'h00, 2'b01));
    tv.push_back(mk(N, N,N,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0010,32'h00, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,N,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0014,32'h00, 2'b01,2'b01,2'b01, 32'hA0,32'h00, 2'b00));
    tv.push_back(mk(N, N,N,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0018,32'h00, 2'b01,2'b01,2'b01, 32'hA1,32'h00, 2'b00));
    tv.push_back(mk(N, N,N,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h001C,32'h00, 2'b01,2'b01,2'b01, 32'hA2,32'h00, 2'b00));
    tv.push_back(mk(N, N,N,2'd3,16'h0010,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'hA3,32'h00, 2'b01));
    // reset, then both ports request single beats: p0, p1, p0, p1
    tv.push_back(mk(Y, N,N,2'd0,16'h0000,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'hA3,32'h00, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0010,32'h00, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'hA0,32'h00, 2'b01));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0014,32'h00, 2'b10,2'b10,2'b00, 32'hA0,32'h00, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b10, 32'hA0,32'hA1, 2'b10));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0010,32'h00, 2'b01,2'b01,2'b00, 32'hA0,32'hA1, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0010,32'h00, Y,N,2'd0,16'h0014,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'hA0,32'hA1, 2'b01));
    tv.push_back(mk(N, N,N,2'd0,16'h0010,32'h00, N,N,2'd0,16'h0014,32'h00, N,16'h0014,32'h00, 2'b10,2'b10,2'b00, 32'hA0,32'hA1, 2'b00));
    // p1 3-beat read, p0 requests mid-burst and waits for the next IDLE
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, Y,N,2'd2,16'h0010,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b10, 32'hA0,32'hA1, 2'b10));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, N,N,2'd2,16'h0010,32'h00, N,16'h0010,32'h00, 2'b10,2'b10,2'b00, 32'hA0,32'hA1, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h001C,32'h00, N,N,2'd2,16'h0010,32'h00, N,16'h0014,32'h00, 2'b10,2'b10,2'b10, 32'hA0,32'hA0, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h001C,32'h00, N,N,2'd2,16'h0010,32'h00, N,16'h0018,32'h00, 2'b10,2'b10,2'b10, 32'hA0,32'hA1, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h001C,32'h00, N,N,2'd2,16'h0010,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b10, 32'hA0,32'hA2, 2'b10));
    tv.push_back(mk(N, N,N,2'd0,16'h001C,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h001C,32'h00, 2'b01,2'b01,2'b00, 32'hA0,32'hA2, 2'b00));
    // p1 write wrapping past the top of the address space, then readback
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, Y,Y,2'd1,16'hFFFC,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'hA3,32'hA2, 2'b01));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, N,Y,2'd1,16'hFFFC,32'h11, Y,16'hFFFC,32'h11, 2'b10,2'b10,2'b00, 32'hA3,32'hA2, 2'b00));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, N,Y,2'd1,16'hFFFC,32'h22, Y,16'h0000,32'h22, 2'b10,2'b10,2'b00, 32'hA3,32'hA2, 2'b00));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, Y,N,2'd1,16'hFFFC,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'hA3,32'hA2, 2'b10));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, N,N,2'd1,16'hFFFC,32'h00, N,16'hFFFC,32'h00, 2'b10,2'b10,2'b00, 32'hA3,32'hA2, 2'b00));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, N,N,2'd1,16'hFFFC,32'h00, N,16'h0000,32'h00, 2'b10,2'b10,2'b10, 32'hA3,32'h11, 2'b00));
    // p0 read from an unaligned address lands on the enclosing word
    tv.push_back(mk(N, Y,N,2'd0,16'h0013,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b10, 32'hA3,32'h22, 2'b10));
    tv.push_back(mk(N, N,N,2'd0,16'h0013,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0010,32'h00, 2'b01,2'b01,2'b00, 32'hA3,32'h22, 2'b00));
    // p0 4-beat write aborted by reset during beat 2
    tv.push_back(mk(N, Y,Y,2'd3,16'h0040,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'hA0,32'h22, 2'b01));
    tv.push_back(mk(N, N,Y,2'd3,16'h0040,32'hB0, N,N,2'd0,16'h0000,32'h00, Y,16'h0040,32'hB0, 2'b01,2'b01,2'b00, 32'hA0,32'h22, 2'b00));
    tv.push_back(mk(Y, N,Y,2'd3,16'h0040,32'hB1, N,N,2'd0,16'h0000,32'h00, Y,16'h0044,32'hB1, 2'b01,2'b01,2'b00, 32'hA0,32'h22, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0040,32'hB2, Y,N,2'd0,16'h0044,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,N,2'd0,16'h0040,32'h00, Y,N,2'd0,16'h0044,32'h00, N,16'h0040,32'h00, 2'b01,2'b01,2'b00, 32'h00,32'h00, 2'b00));
    tv.push_back(mk(N, N,N,2'd0,16'h0040,32'h00, Y,N,2'd0,16'h0044,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'hB0,32'h00, 2'b01));
    tv.push_back(mk(N, N,N,2'd0,16'h0040,32'h00, N,N,2'd0,16'h0044,32'h00, N,16'h0044,32'h00, 2'b10,2'b10,2'b00, 32'hB0,32'h00, 2'b00));
    tv.push_back(mk(N, Y,N,2'd0,16'h0048,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b10, 32'hB0,32'hB1, 2'b10));
    tv.push_back(mk(N, N,N,2'd0,16'h0048,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0048,32'h00, 2'b01,2'b01,2'b00, 32'hB0,32'hB1, 2'b00));
    tv.push_back(mk(N, N,N,2'd0,16'h0000,32'h00, N,N,2'd0,16'h0000,32'h00, N,16'h0000,32'h00, 2'b00,2'b00,2'b01, 32'h00,32'hB1, 2'b01));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      act_v = {7'd0, MemWrite, Addr, WriteData, p1_if.gnt, p0_if.gnt, p1_if.beat, p0_if.beat,
               p1_if.rvalid, p0_if.rvalid, p0_if.rdata, p1_if.rdata, p1_if.done, p0_if.done};
      exp_v = {7'd0, tv[i].mw, tv[i].addr, tv[i].wd, tv[i].gnt, tv[i].beat, tv[i].rv,
               tv[i].rd0, tv[i].rd1, tv[i].dn};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end

    // Sustained requests from both ports: p1 holds the tie after p0's last burst.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.len = 2'd0; p0_if.addr = 16'h0010; p0_if.wdata = 32'h0;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.len = 2'd0; p1_if.addr = 16'h0014; p1_if.wdata = 32'h0;
      end
      #1;
      chk($sformatf("rr%0d", k), {126'd0, p1_if.gnt, p0_if.gnt},
          {126'd0, (k % 2 == 1) ? ((((k >> 1) & 1) == 0) ? 2'b10 : 2'b01) : 2'b00});
    end
    @(negedge clk);
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;
    repeat (3) @(negedge clk);

    chk("mem_ffc", {96'd0, mem[14'h3FFF]}, {96'd0, 32'h11});
    chk("mem_000", {96'd0, mem[14'h0000]}, {96'd0, 32'h22});
    chk("mem_01c", {96'd0, mem[14'h0007]}, {96'd0, 32'hA3});
    chk("mem_040", {96'd0, mem[14'h0010]}, {96'd0, 32'hB0});
    chk("mem_044", {96'd0, mem[14'h0011]}, {96'd0, 32'hB1});
    chk("mem_048", {96'd0, mem[14'h0012]}, {96'd0, 32'h00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
